// File: rtl/fsm_core_if.sv
// Command/status bundle for the loadable down-counter FSM.
// in_i carries {start, stop, pause, load[3:0]}; out_o carries {state[2:0], count[3:0]}.
interface fsm_core_if;
   logic [6:0] in_i;
   logic [6:0] out_o;

   modport master (
      output in_i,
      input  out_o
   );

   modport slave (
      input  in_i,
      output out_o
   );
endinterface

// File: rtl/fsm_core.sv
// fsm_core: loadable down-counter control FSM.
// A 7-bit command word (start/stop/pause/load) is sampled on every rising edge.
// The registered state code and the counter value are reported on a 7-bit Moore
// output, so there is no combinational path from the command word to the output.
// Optional feature macro: FSM_AUTORELOAD_EN. When it is defined, a start with a
// non-zero load value in DONE reloads directly into LOAD. When it is undefined,
// DONE always falls back to IDLE.
module fsm_core #(
   parameter int IN_LEN   = 7,
   parameter int OUT_LEN  = 7,
   parameter int ERR_ZERO = 1
) (
   input  logic        clk,
   input  logic        rst,
   fsm_core_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      COUNT = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;

   state_t        state_q;
   logic [3:0]    count_q;

   logic [IN_LEN-1:0]  cmdWord;
   logic [OUT_LEN-1:0] outWord;
   logic               startCmd;
   logic               stopCmd;
   logic               pauseCmd;
   logic [3:0]         loadVal;
   logic               loadIsZero;

   // Split the command word into its fields.
   assign cmdWord    = bus.in_i;
   assign startCmd   = cmdWord[6];
   assign stopCmd    = cmdWord[5];
   assign pauseCmd   = cmdWord[4];
   assign loadVal    = cmdWord[3:0];
   assign loadIsZero = (loadVal == 4'd0);

   // The output is just the registered state and count, giving Moore behaviour.
   assign outWord = {state_q, count_q};
   assign bus.out_o = outWord;

   // Single sequential FSM. Within each state the commands are checked in
   // priority order: stop first, then pause, then start. Reset overrides every command.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               count_q <= 4'd0;
               if (stopCmd || pauseCmd) begin
                  state_q <= IDLE;
               end else if (startCmd && !loadIsZero) begin
                  state_q <= LOAD;
                  count_q <= loadVal;
               end else if (startCmd) begin
                  state_q <= (ERR_ZERO != 0) ? ERR : DONE;
               end else begin
                  state_q <= IDLE;
               end
            end
            LOAD: begin
               if (stopCmd) begin
                  state_q <= IDLE;
                  count_q <= 4'd0;
               end else begin
                  state_q <= COUNT;
               end
            end
            COUNT: begin
               if (stopCmd) begin
                  state_q <= IDLE;
                  count_q <= 4'd0;
               end else if (pauseCmd) begin
                  state_q <= PAUSE;
               end else if (count_q <= 4'd1) begin
                  state_q <= DONE;
                  count_q <= 4'd0;
               end else begin
                  count_q <= count_q - 4'd1;
               end
            end
            PAUSE: begin
               if (stopCmd) begin
                  state_q <= IDLE;
                  count_q <= 4'd0;
               end else if (!pauseCmd) begin
                  state_q <= COUNT;
               end
            end
            DONE: begin
               count_q <= 4'd0;
               state_q <= IDLE;
`ifdef FSM_AUTORELOAD_EN
               if (!stopCmd && !pauseCmd && startCmd) begin
                  if (!loadIsZero) begin
                     state_q <= LOAD;
                     count_q <= loadVal;
                  end else begin
                     state_q <= (ERR_ZERO != 0) ? ERR : DONE;
                  end
               end
`endif
            end
            ERR: begin
               count_q <= 4'd0;
               if (stopCmd) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               count_q <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fsm_core.sv
// Directed self-checking bench for fsm_core. It applies one command word per
// cycle and compares the registered output against hand-computed expected values.
module tb_fsm_core;

   logic clk;
   logic rst;
   int   checksTotal;
   int   checksPassed;

   fsm_core_if busIf ();

   fsm_core #(
      .IN_LEN   (7),
      .OUT_LEN  (7),
      .ERR_ZERO (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (busIf.slave)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs are driven on the falling edge. The output is sampled 1 unit after
   // the following rising edge.
   task automatic applyStimulus(input logic rstVal, input logic [6:0] inVal);
      @(negedge clk);
      rst        = rstVal;
      busIf.in_i = inVal;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input logic [6:0] expected, input string tag);
      logic [6:0] observed;
      observed = busIf.out_o;
      checksTotal++;
      assert (observed === expected) begin
         checksPassed++;
      end else begin
         $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
      end
   endtask

   task automatic step(input logic rstVal, input logic [6:0] inVal,
                       input logic [6:0] expected, input string tag);
      applyStimulus(rstVal, inVal);
      checkOutput(expected, tag);
   endtask

   // Linear sequence of directed steps.
   initial begin
      logic [6:0] reloadExp;
      checksTotal  = 0;
      checksPassed = 0;
      rst          = 1'b1;
      busIf.in_i   = 7'h7F;

      // Reset holds its value even with every command bit asserted.
      step(1'b1, 7'h7F, 7'h00, "reset1");
      step(1'b1, 7'h7F, 7'h00, "reset2");
      step(1'b0, 7'h00, 7'h00, "idleAfterReset");

      // Load 3 and count down to DONE, then return to IDLE.
      step(1'b0, 7'b1000011, 7'h13, "load3");
      step(1'b0, 7'h00, 7'h23, "count3");
      step(1'b0, 7'h00, 7'h22, "count2");
      step(1'b0, 7'h00, 7'h21, "count1");
      step(1'b0, 7'h00, 7'h40, "done");
      step(1'b0, 7'h00, 7'h00, "idleAfterDone");

      // Pause at count 5, then resume the count.
      step(1'b0, 7'b1000101, 7'h15, "load5");
      step(1'b0, 7'h00, 7'h25, "count5");
      step(1'b0, 7'b0010000, 7'h35, "pause1");
      step(1'b0, 7'b0010000, 7'h35, "pause2");
      step(1'b0, 7'b0010000, 7'h35, "pause3");
      step(1'b0, 7'h00, 7'h25, "resume");
      step(1'b0, 7'h00, 7'h24, "resumeDec");

      // Start has no effect while counting.
      step(1'b0, 7'b1001111, 7'h23, "startIgnoredInCount");

      // Stop and pause together: stop takes priority.
      step(1'b0, 7'b0110000, 7'h00, "stopBeatsPause");

      // A start with load 0 enters the sticky ERR state.
      step(1'b0, 7'b1000000, 7'h50, "errEnter");
      step(1'b0, 7'h00, 7'h50, "errHold");
      step(1'b0, 7'b1000101, 7'h50, "errStartIgnored");
      step(1'b0, 7'b0010000, 7'h50, "errPauseIgnored");
      step(1'b0, 7'b0100000, 7'h00, "errStop");

      // Stop and pause in IDLE are ignored.
      step(1'b0, 7'b0110101, 7'h00, "idleStopPause");

      // A stop during the single LOAD cycle returns to IDLE.
      step(1'b0, 7'b1000111, 7'h17, "load7");
      step(1'b0, 7'b0100000, 7'h00, "stopInLoad");

      // A start in DONE either reloads or is ignored, depending on the build.
      step(1'b0, 7'b1000001, 7'h11, "load1");
      step(1'b0, 7'h00, 7'h21, "count1b");
      step(1'b0, 7'h00, 7'h40, "doneFromOne");
`ifdef FSM_AUTORELOAD_EN
      reloadExp = 7'h12;
`else
      reloadExp = 7'h00;
`endif
      step(1'b0, 7'b1000010, reloadExp, "doneStart");
      step(1'b0, 7'b0100000, 7'h00, "stopAfterDoneStart");

      // Reset in the middle of a count.
      step(1'b0, 7'b1000100, 7'h14, "load4");
      step(1'b0, 7'h00, 7'h24, "count4");
      step(1'b1, 7'h00, 7'h00, "resetMidCount");
      step(1'b0, 7'h00, 7'h00, "idleAfterMidReset");

      // A full load-4 run reaches DONE five edges after the load.
      step(1'b0, 7'b1000100, 7'h14, "latLoad");
      step(1'b0, 7'h00, 7'h24, "lat1");
      step(1'b0, 7'h00, 7'h23, "lat2");
      step(1'b0, 7'h00, 7'h22, "lat3");
      step(1'b0, 7'h00, 7'h21, "lat4");
      step(1'b0, 7'h00, 7'h40, "latDone");

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
